gemm_operand_ram: RTL and testbench

- Parametrised, writable operand store for the GEMM datapath. Holds one DIM x DIM signed matrix tile in row-major order (addr = row*DIM + col).
- Streams NCH rows (ROW mode) or NCH columns (COL mode) in parallel, one element per channel per cycle, to the MAC array.
- Generalises the fixed 64x8-bit dual-read operand ROM with:
  - a host load port,
  - configurable width, dimension and channel count,
  - an internal address-generating stream FSM with valid/done signalling and edge zero-padding.

---
 rtl/gemm_operand_ram_if.sv | 39 +++
 rtl/gemm_operand_ram.sv | 171 +++++++++++++++++
 tb/tb_gemm_operand_ram.sv | 261 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/gemm_operand_ram_if.sv
// gemm_operand_ram_if
//   Bundles the host load port, the stream control port and the stream
//   read-out of gemm_operand_ram.
//   master : host side (drives writes and start/mode/base, observes stream)
//   slave  : operand store side
//   Signals:
//     wr_en/wr_addr/wr_data      host write into the tile (row-major address)
//     start/mode/base            request one ROW (mode=0) or COL (mode=1) stream
//     busy                       stream in progress
//     rd_valid/rd_k/rd_data/done stream beat, element index, NCH lanes, last beat
interface gemm_operand_ram_if #(
  parameter int DW  = 8,
  parameter int DIM = 8,
  parameter int NCH = 2,
  parameter int AW  = $clog2(DIM * DIM),
  parameter int IW  = $clog2(DIM)
);
  logic              wr_en;
  logic [AW-1:0]     wr_addr;
  logic [DW-1:0]     wr_data;
  logic              start;
  logic              mode;
  logic [IW-1:0]     base;
  logic              busy;
  logic              rd_valid;
  logic [IW-1:0]     rd_k;
  logic [NCH*DW-1:0] rd_data;
  logic              done;

  modport master (
    output wr_en, wr_addr, wr_data, start, mode, base,
    input  busy, rd_valid, rd_k, rd_data, done
  );

  modport slave (
    input  wr_en, wr_addr, wr_data, start, mode, base,
    output busy, rd_valid, rd_k, rd_data, done
  );
endinterface

// File: rtl/gemm_operand_ram.sv
// gemm_operand_ram
//   Writable DIM x DIM signed operand tile (row-major, addr = row*DIM + col)
//   that streams NCH rows or NCH columns in parallel to the MAC array, one
//   element per channel per cycle, with a one-cycle registered read.
//   Ports:
//     clk   rising-edge clock
//     rst_n asynchronous active-low reset (memory contents are retained)
//     bus   gemm_operand_ram_if.slave: host writes, start/mode/base,
//           busy, rd_valid, rd_k, rd_data, done
//   Channel i streams line base+i; a line past the tile edge yields zeros.
module gemm_operand_ram #(
  parameter int DW  = 8,
  parameter int DIM = 8,
  parameter int NCH = 2,
  parameter int AW  = $clog2(DIM * DIM),
  parameter int IW  = $clog2(DIM)
) (
  input  logic               clk,
  input  logic               rst_n,
  gemm_operand_ram_if.slave  bus
);

  localparam int DEPTH = DIM * DIM;
  // base + i reaches up to 2*DIM-2, so one extra bit keeps the edge test exact
  localparam int LW = IW + 1;
  localparam logic [AW:0]     DEPTH_L = (AW + 1)'(DEPTH);
  localparam logic [LW-1:0]   DIM_L   = LW'(DIM);
  localparam logic [IW-1:0]   K_LAST  = IW'(DIM - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_STREAM = 2'd1,
    S_DRAIN  = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic              mode_q, mode_d;
  logic [IW-1:0]     base_q, base_d;
  logic [IW-1:0]     k_q, k_d;
  logic              busy_q, busy_d;
  logic              rd_valid_q, rd_valid_d;
  logic              done_q, done_d;
  logic [IW-1:0]     rd_k_q, rd_k_d;
  logic [NCH*DW-1:0] rd_data_q, rd_data_d;

  logic [DW-1:0]     mem [DEPTH];
  logic              wr_fire_s;
  logic [LW-1:0]     line_s  [NCH];
  logic              pad_s   [NCH];
  logic [AW-1:0]     raddr_s [NCH];

  // Host writes only land while idle and inside the tile.
  always_comb begin
    wr_fire_s = 1'b0;
    if (bus.wr_en && (state_q == S_IDLE) && ({1'b0, bus.wr_addr} < DEPTH_L)) begin
      wr_fire_s = 1'b1;
    end else begin
      wr_fire_s = 1'b0;
    end
  end

  // Tile storage: no reset so the operands survive a reset of the control path.
  always_ff @(posedge clk) begin
    if (wr_fire_s) begin
      mem[bus.wr_addr] <= bus.wr_data;
    end
  end

  // Per-channel line index, edge flag and row-major read address.
  always_comb begin
    for (int i = 0; i < NCH; i++) begin
      line_s[i]  = {1'b0, base_q} + LW'(i);
      pad_s[i]   = (line_s[i] >= DIM_L);
      raddr_s[i] = '0;
      // Address is only formed for in-tile lines, where it is < DIM*DIM.
      if (pad_s[i]) begin
        raddr_s[i] = '0;
      end else if (mode_q) begin
        raddr_s[i] = AW'(k_q) * AW'(DIM) + AW'(line_s[i]);
      end else begin
        raddr_s[i] = AW'(line_s[i]) * AW'(DIM) + AW'(k_q);
      end
    end
  end

  // Stream FSM next state, address counter and next values of the outputs.
  always_comb begin
    state_d    = state_q;
    mode_d     = mode_q;
    base_d     = base_q;
    k_d        = k_q;
    busy_d     = busy_q;
    rd_valid_d = 1'b0;
    done_d     = 1'b0;
    rd_k_d     = rd_k_q;
    rd_data_d  = rd_data_q;
    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          state_d = S_STREAM;
          mode_d  = bus.mode;
          base_d  = bus.base;
          k_d     = '0;
          busy_d  = 1'b1;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_STREAM: begin
        // Read issued now is presented next cycle as beat k.
        rd_valid_d = 1'b1;
        rd_k_d     = k_q;
        for (int i = 0; i < NCH; i++) begin
          if (pad_s[i]) begin
            rd_data_d[i*DW +: DW] = '0;
          end else begin
            rd_data_d[i*DW +: DW] = mem[raddr_s[i]];
          end
        end
        if (k_q == K_LAST) begin
          state_d = S_DRAIN;
          done_d  = 1'b1;
          k_d     = '0;
        end else begin
          k_d = k_q + IW'(1);
        end
      end
      S_DRAIN: begin
        // Last beat is on the outputs this cycle; busy falls after it.
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State and output registers; reset aborts any stream without a done pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      mode_q     <= 1'b0;
      base_q     <= '0;
      k_q        <= '0;
      busy_q     <= 1'b0;
      rd_valid_q <= 1'b0;
      done_q     <= 1'b0;
      rd_k_q     <= '0;
      rd_data_q  <= '0;
    end else begin
      state_q    <= state_d;
      mode_q     <= mode_d;
      base_q     <= base_d;
      k_q        <= k_d;
      busy_q     <= busy_d;
      rd_valid_q <= rd_valid_d;
      done_q     <= done_d;
      rd_k_q     <= rd_k_d;
      rd_data_q  <= rd_data_d;
    end
  end

  assign bus.busy     = busy_q;
  assign bus.rd_valid = rd_valid_q;
  assign bus.rd_k     = rd_k_q;
  assign bus.rd_data  = rd_data_q;
  assign bus.done     = done_q;

endmodule

// File: tb/tb_gemm_operand_ram.sv
// tb_gemm_operand_ram
//   Self-checking bench for gemm_operand_ram (DW=8, DIM=8, NCH=2).
//   Expected beats are pushed to a scoreboard queue when a stream is started
//   and popped/compared by a negedge monitor whenever rd_valid is high.
module tb_gemm_operand_ram;

  localparam int DW  = 8;
  localparam int DIM = 8;
  localparam int NCH = 2;
  localparam int AW  = $clog2(DIM * DIM);
  localparam int IW  = $clog2(DIM);

  typedef struct {
    int                cyc;
    logic [IW-1:0]     k;
    logic [NCH*DW-1:0] data;
    logic              done;
  } beat_t;

  logic clk = 1'b0;
  logic rst_n;
  int   cyc    = 0;
  int   checks = 0;
  int   errors = 0;

  beat_t         sb[$];
  logic [DW-1:0] model [DIM*DIM];

  gemm_operand_ram_if #(.DW(DW), .DIM(DIM), .NCH(NCH)) bus ();

  gemm_operand_ram #(.DW(DW), .DIM(DIM), .NCH(NCH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard monitor: every valid beat must match the oldest expected beat.
  always @(negedge clk) begin
    beat_t e;
    if (rst_n === 1'b1 && bus.rd_valid === 1'b1) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_beat: cyc=%0d k=%0d data=%h done=%b, required no beat",
                 cyc, bus.rd_k, bus.rd_data, bus.done);
      end else begin
        e = sb.pop_front();
        if (cyc !== e.cyc || bus.rd_k !== e.k || bus.rd_data !== e.data || bus.done !== e.done) begin
          errors++;
          $display("FAIL beat: got cyc=%0d k=%0d data=%h done=%b, required cyc=%0d k=%0d data=%h done=%b",
                   cyc, bus.rd_k, bus.rd_data, bus.done, e.cyc, e.k, e.data, e.done);
        end
      end
    end else if (rst_n === 1'b1 && bus.done === 1'b1) begin
      checks++;
      errors++;
      $display("FAIL done_without_valid: cyc=%0d done=%b rd_valid=%b, required done=0",
               cyc, bus.done, bus.rd_valid);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: time=%0t, required completion", $time);
    $fatal(1, "watchdog expired");
  end

  // Expected beats of a stream started in cycle t0 (first nbeats beats).
  function automatic void push_stream(input logic m, input logic [IW-1:0] b,
                                      input int t0, input int nbeats);
    beat_t e;
    for (int k = 0; k < nbeats; k++) begin
      e.cyc  = t0 + 2 + k;
      e.k    = IW'(k);
      e.done = (k == DIM - 1);
      e.data = '0;
      for (int i = 0; i < NCH; i++) begin
        int line;
        line = int'(b) + i;
        if (line < DIM) begin
          e.data[i*DW +: DW] = m ? model[k*DIM + line] : model[line*DIM + k];
        end
      end
      sb.push_back(e);
    end
  endfunction

  // One stream. Called at posedge+1 (cycle T). wr_off/st_off give the cycle
  // offset of an extra write / extra start pulse (-1: none). Returns at
  // posedge+1 of cycle T+last_off+1.
  task automatic do_stream(input logic m, input logic [IW-1:0] b,
                           input int wr_off, input logic [AW-1:0] wa,
                           input logic [DW-1:0] wd, input int st_off,
                           input int last_off);
    int t0;
    t0 = cyc;
    if (wr_off == 0) model[wa] = wd;
    push_stream(m, b, t0, DIM);
    bus.start   = 1'b1;
    bus.mode    = m;
    bus.base    = b;
    bus.wr_en   = (wr_off == 0);
    bus.wr_addr = wa;
    bus.wr_data = wd;
    @(negedge clk);
    checks++;
    if (bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL busy_at_start: cyc=%0d busy=%b, required 0", cyc, bus.busy);
    end
    @(posedge clk); #1;
    bus.mode = ~m;
    bus.base = b + IW'(1);
    for (int c = 1; c <= last_off; c++) begin
      bus.start = (c == st_off);
      bus.wr_en = (c == wr_off);
      @(negedge clk);
      checks++;
      if (bus.busy !== 1'((c <= DIM + 1))) begin
        errors++;
        $display("FAIL busy: offset=%0d busy=%b, required %b", c, bus.busy, (c <= DIM + 1));
      end
      @(posedge clk); #1;
    end
    bus.start = 1'b0;
    bus.wr_en = 1'b0;
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL missing_beats: outstanding=%0d, required 0", sb.size());
      sb.delete();
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (bus.busy !== 1'b0 || bus.rd_valid !== 1'b0 || bus.done !== 1'b0) begin
      errors++;
      $display("FAIL reset_ctrl: busy=%b rd_valid=%b done=%b, required 0 0 0",
               bus.busy, bus.rd_valid, bus.done);
    end
    checks++;
    if (bus.rd_k !== '0 || bus.rd_data !== '0) begin
      errors++;
      $display("FAIL reset_data: rd_k=%0d rd_data=%h, required 0 0", bus.rd_k, bus.rd_data);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_load();
    for (int a = 0; a < DIM * DIM; a++) begin
      bus.wr_en   = 1'b1;
      bus.wr_addr = AW'(a);
      bus.wr_data = DW'(a);
      model[a]    = DW'(a);
      @(posedge clk); #1;
    end
    bus.wr_en = 1'b0;
  endtask

  task automatic test_row_stream();
    do_stream(1'b0, 3'd3, -1, '0, '0, -1, DIM + 2);
  endtask

  task automatic test_col_stream();
    do_stream(1'b1, 3'd5, -1, '0, '0, -1, DIM + 2);
  endtask

  task automatic test_row_padding();
    do_stream(1'b0, 3'd7, -1, '0, '0, -1, DIM + 2);
    do_stream(1'b1, 3'd7, -1, '0, '0, -1, DIM + 2);
  endtask

  // Second start lands in the first IDLE cycle after DRAIN.
  task automatic test_back_to_back();
    do_stream(1'b1, 3'd0, -1, '0, '0, -1, DIM + 1);
    do_stream(1'b0, 3'd6, -1, '0, '0, -1, DIM + 2);
  endtask

  // Start re-pulsed at T+4 and a write at T+3 while busy: both ignored.
  task automatic test_collisions();
    do_stream(1'b0, 3'd3, 3, 6'd24, 8'h7F, 4, DIM + 2);
    do_stream(1'b0, 3'd3, -1, '0, '0, -1, DIM + 2);
  endtask

  // Write and start in the same IDLE cycle: the stream sees the new value.
  task automatic test_write_with_start();
    do_stream(1'b0, 3'd5, 0, 6'd40, 8'h80, -1, DIM + 2);
  endtask

  task automatic test_reset_midstream();
    int t0;
    t0 = cyc;
    push_stream(1'b0, 3'd3, t0, 3);
    bus.start = 1'b1;
    bus.mode  = 1'b0;
    bus.base  = 3'd3;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (4) begin
      @(posedge clk); #1;
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (bus.busy !== 1'b0 || bus.rd_valid !== 1'b0 || bus.done !== 1'b0 ||
        bus.rd_k !== '0 || bus.rd_data !== '0) begin
      errors++;
      $display("FAIL midstream_reset: busy=%b valid=%b done=%b k=%0d data=%h, required all 0",
               bus.busy, bus.rd_valid, bus.done, bus.rd_k, bus.rd_data);
    end
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL pre_reset_beats: outstanding=%0d, required 0", sb.size());
      sb.delete();
    end
    repeat (2) begin
      @(posedge clk); #1;
    end
    rst_n = 1'b1;
    for (int c = 0; c < DIM + 2; c++) begin
      @(negedge clk);
      checks++;
      if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin
        errors++;
        $display("FAIL after_abort: cyc=%0d busy=%b done=%b, required 0 0", cyc, bus.busy, bus.done);
      end
    end
    @(posedge clk); #1;
    do_stream(1'b0, 3'd3, -1, '0, '0, -1, DIM + 2);
  endtask

  initial begin
    bus.wr_en   = 1'b0;
    bus.wr_addr = '0;
    bus.wr_data = '0;
    bus.start   = 1'b0;
    bus.mode    = 1'b0;
    bus.base    = '0;
    test_reset();
    test_load();
    test_row_stream();
    test_col_stream();
    test_row_padding();
    test_back_to_back();
    test_collisions();
    test_write_with_start();
    test_reset_midstream();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
